brick_wall_ctrl: RTL and testbench

Controller for the brick wall of the Breakout datapath. It owns the alive bitmap of an N_ROWS x N_COLS wall and the wall's vertical descent offset. On each frame tick it scans the bricks sequentially, one per clock, against the ball position, and resolves the first hit: it clears the brick, scores it and reports the bounce axis to the ball controller. It also reports endgame when a surviving row reaches the bottom, and level clear when no bricks remain.

---
 rtl/brick_wall_ctrl.sv | 170 +++++++++++++++++
 tb/tb_brick_wall_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brick_wall_ctrl.sv
// ============================================================================
// brick_wall_ctrl : Breakout brick wall - alive bitmap, descent, hit scan
// Rev 1.0
// ============================================================================
`default_nettype none

module brick_wall_ctrl #(
  parameter int N_COLS      = 10,
  parameter int N_ROWS      = 4,
  parameter int X0          = 32,
  parameter int Y0          = 40,
  parameter int W_BLOCK     = 32,
  parameter int H_BLOCK     = 8,
  parameter int R_BALL      = 8,
  parameter int DROP_FRAMES = 600,
  parameter int DROP_PX     = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       frame_tick,
  input  logic [9:0]                 x_ball,
  input  logic [9:0]                 y_ball,
  output logic [N_ROWS*N_COLS-1:0]   alive,
  output logic [9:0]                 y_offset,
  output logic                       hit_block,
  output logic                       bounce_x,
  output logic                       bounce_y,
  output logic [7:0]                 score,
  output logic                       busy,
  output logic                       endgame,
  output logic                       all_clear
);

  localparam int N  = N_ROWS * N_COLS;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int RW = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int FW = $clog2(DROP_FRAMES + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SCAN    = 2'd1,
    S_RESOLVE = 2'd2
  } state_t;

  state_t          r_state, w_next;
  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [9:0]      r_xb, r_yb, r_scan_off;
  logic [FW-1:0]   r_frames;
  logic            r_axis_y;

  logic signed [11:0] w_xc, w_yc, w_dx, w_dy, w_adx, w_ady, w_dx_pen, w_dy_pen;
  logic               w_hit, w_axis_y, w_accept, w_last, w_reach;

  assign busy      = (r_state != S_IDLE);
  assign all_clear = ~|alive;
  assign w_accept  = (r_state == S_IDLE) && frame_tick && start && !endgame && !all_clear;
  assign w_last    = (r_idx == IW'(N - 1));

  // Geometry of the brick under test; the scan uses the offset captured at acceptance.
  always_comb begin
    w_xc     = 12'(X0) + 12'(r_col) * 12'(2 * W_BLOCK);
    w_yc     = 12'(Y0) + 12'(r_row) * 12'(2 * H_BLOCK) + {2'b00, r_scan_off};
    w_dx     = $signed({2'b00, r_xb}) - w_xc;
    w_dy     = $signed({2'b00, r_yb}) - w_yc;
    w_adx    = w_dx[11] ? -w_dx : w_dx;
    w_ady    = w_dy[11] ? -w_dy : w_dy;
    w_dx_pen = 12'(W_BLOCK + R_BALL) - w_adx;
    w_dy_pen = 12'(H_BLOCK + R_BALL) - w_ady;
    w_hit    = alive[r_idx] && !w_dx_pen[11] && !w_dy_pen[11];
    w_axis_y = (w_dy_pen <= w_dx_pen);
  end

  always_comb begin
    w_reach = 1'b0;
    for (int r = 0; r < N_ROWS; r++) begin
      if ((|alive[r*N_COLS +: N_COLS]) &&
          ((12'(Y0 + r * 2 * H_BLOCK + H_BLOCK) + {2'b00, y_offset}) >= 12'd464))
        w_reach = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_SCAN;
      S_SCAN: begin
        if (w_hit)       w_next = S_RESOLVE;
        else if (w_last) w_next = S_IDLE;
      end
      S_RESOLVE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      alive      <= '1;
      y_offset   <= '0;
      score      <= '0;
      r_frames   <= '0;
      hit_block  <= 1'b0;
      bounce_x   <= 1'b0;
      bounce_y   <= 1'b0;
      endgame    <= 1'b0;
      r_idx      <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_xb       <= '0;
      r_yb       <= '0;
      r_scan_off <= '0;
      r_axis_y   <= 1'b0;
    end else begin
      hit_block <= 1'b0;
      bounce_x  <= 1'b0;
      bounce_y  <= 1'b0;
      endgame   <= endgame | w_reach;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_xb       <= x_ball;
            r_yb       <= y_ball;
            r_idx      <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_scan_off <= y_offset;
            if (r_frames == FW'(DROP_FRAMES - 1)) begin
              r_frames <= '0;
              y_offset <= y_offset + 10'(DROP_PX);
            end else begin
              r_frames <= r_frames + FW'(1);
            end
          end
        end
        S_SCAN: begin
          if (w_hit) begin
            r_axis_y <= w_axis_y;
          end else if (!w_last) begin
            r_idx <= r_idx + IW'(1);
            if (r_col == CW'(N_COLS - 1)) begin
              r_col <= '0;
              r_row <= r_row + RW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        S_RESOLVE: begin
          alive[r_idx] <= 1'b0;
          if (score != 8'hFF) score <= score + 8'd1;
          hit_block <= 1'b1;
          bounce_y  <= r_axis_y;
          bounce_x  <= !r_axis_y;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_brick_wall_ctrl.sv
// ============================================================================
// tb_brick_wall_ctrl : randomized self-checking bench with a geometric model
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_brick_wall_ctrl;

  localparam int N_COLS = 10, N_ROWS = 4, N = 40;
  localparam int X0 = 32, Y0 = 40, W_BLOCK = 32, H_BLOCK = 8, R_BALL = 8;
  localparam int DROP_FRAMES = 600, DROP_PX = 16;

  logic clock = 1'b0;
  logic reset, start, frame_tick;
  logic [9:0] x_ball, y_ball;
  logic [N-1:0] alive;
  logic [9:0] y_offset;
  logic hit_block, bounce_x, bounce_y;
  logic [7:0] score;
  logic busy, endgame, all_clear;

  logic d_start, d_frame_tick;
  logic [9:0] d_x_ball, d_y_ball;
  logic [N-1:0] d_alive;
  logic [9:0] d_y_offset;
  logic d_hit_block, d_bounce_x, d_bounce_y;
  logic [7:0] d_score;
  logic d_busy, d_endgame, d_all_clear;

  int vectors = 0, miscompares = 0;

  bit m_alive[N];
  int m_score, m_off, m_frames;
  bit m_endgame;

  always #5 clock = ~clock;

  brick_wall_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .frame_tick(frame_tick),
    .x_ball(x_ball), .y_ball(y_ball), .alive(alive), .y_offset(y_offset),
    .hit_block(hit_block), .bounce_x(bounce_x), .bounce_y(bounce_y),
    .score(score), .busy(busy), .endgame(endgame), .all_clear(all_clear)
  );

  brick_wall_ctrl #(.DROP_FRAMES(1)) dut_drop (
    .clock(clock), .reset(reset), .start(d_start), .frame_tick(d_frame_tick),
    .x_ball(d_x_ball), .y_ball(d_y_ball), .alive(d_alive), .y_offset(d_y_offset),
    .hit_block(d_hit_block), .bounce_x(d_bounce_x), .bounce_y(d_bounce_y),
    .score(d_score), .busy(d_busy), .endgame(d_endgame), .all_clear(d_all_clear)
  );

  // ---------------- reference model ----------------
  function automatic logic [N-1:0] model_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_alive[i];
    return v;
  endfunction

  function automatic bit model_all_clear();
    for (int i = 0; i < N; i++) if (m_alive[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_reach(input int off);
    for (int r = 0; r < N_ROWS; r++)
      for (int c = 0; c < N_COLS; c++)
        if (m_alive[r*N_COLS+c] && (Y0 + r*2*H_BLOCK + off + H_BLOCK >= 464)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_find(input int x, input int y, input int off,
                            output int idx, output bit axis_y);
    int xc, yc, adx, ady;
    idx = -1; axis_y = 1'b0;
    for (int i = 0; i < N; i++) begin
      xc  = X0 + (i % N_COLS) * 2 * W_BLOCK;
      yc  = Y0 + (i / N_COLS) * 2 * H_BLOCK + off;
      adx = (x > xc) ? x - xc : xc - x;
      ady = (y > yc) ? y - yc : yc - y;
      if (idx < 0 && m_alive[i] && adx <= W_BLOCK + R_BALL && ady <= H_BLOCK + R_BALL) begin
        idx    = i;
        axis_y = ((H_BLOCK + R_BALL - ady) <= (W_BLOCK + R_BALL - adx));
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_alive[i] = 1'b1;
    m_score = 0; m_off = 0; m_frames = 0; m_endgame = 1'b0;
  endtask

  // Expected hit cycle / busy-fall cycle relative to the accepting edge E0.
  task automatic model_apply(input int x, input int y, input bit st,
                             output int e_hit, output int e_fall, output bit e_by);
    int idx; bit ay;
    e_hit = -1; e_fall = 0; e_by = 1'b0;
    if (st && !m_endgame && !model_all_clear()) begin
      model_find(x, y, m_off, idx, ay);
      if (m_frames == DROP_FRAMES - 1) begin m_frames = 0; m_off += DROP_PX; end
      else m_frames++;
      if (idx >= 0) begin
        e_hit = idx + 2; e_fall = idx + 2; e_by = ay;
        m_alive[idx] = 1'b0;
        if (m_score < 255) m_score++;
      end else begin
        e_fall = N;
      end
    end
    m_endgame = m_endgame | model_reach(m_off);
  endtask

  // ---------------- stimulus / observation ----------------
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; frame_tick = 1'b0; d_frame_tick = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic observe_tick(input int x, input int y, input bit st, input bit extra,
                              output int hit_cyc, output bit obx, output bit oby,
                              output int fall, output int nhits);
    @(negedge clock);
    x_ball = 10'(x); y_ball = 10'(y); start = st; frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    x_ball = 10'($urandom); y_ball = 10'($urandom);
    hit_cyc = -1; fall = -1; nhits = 0; obx = 1'b0; oby = 1'b0;
    for (int c = 0; c < N + 6; c++) begin
      if (c > 0) @(negedge clock);
      if (hit_block) begin
        nhits++;
        if (hit_cyc < 0) begin hit_cyc = c; obx = bounce_x; oby = bounce_y; end
      end
      if (!busy && fall < 0) fall = c;
      if (c == 1 && extra) frame_tick = 1'b1;
      if (c == 2) frame_tick = 1'b0;
    end
    start = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    vectors++; if (alive !== {N{1'b1}}) begin miscompares++; $display("FAIL reset_alive: got %h expected %h", alive, {N{1'b1}}); end
    vectors++; if (score !== 8'd0) begin miscompares++; $display("FAIL reset_score: got %0d expected 0", score); end
    vectors++; if (y_offset !== 10'd0) begin miscompares++; $display("FAIL reset_y_offset: got %0d expected 0", y_offset); end
    vectors++; if ({busy, endgame, hit_block, bounce_x, bounce_y, all_clear} !== 6'b0) begin
      miscompares++; $display("FAIL reset_flags: got %b expected 000000", {busy, endgame, hit_block, bounce_x, bounce_y, all_clear}); end
  endtask

  task automatic test_plan_hits();
    int hc, fl, nh, eh, ef; bit bx, by, eby;
    int xs[3] = '{160, 160, 200};
    int ys[3] = '{70, 70, 92};
    int ki[3] = '{12, 22, 32};
    bit ay[3] = '{1'b1, 1'b1, 1'b0};
    for (int t = 0; t < 3; t++) begin
      observe_tick(xs[t], ys[t], 1'b1, 1'b0, hc, bx, by, fl, nh);
      model_apply(xs[t], ys[t], 1'b1, eh, ef, eby);
      vectors++; if (hc !== ki[t] + 2) begin miscompares++; $display("FAIL plan%0d_hit_cycle: got %0d expected %0d", t, hc, ki[t] + 2); end
      vectors++; if ({bx, by} !== {!ay[t], ay[t]}) begin miscompares++; $display("FAIL plan%0d_axis: got bx=%0d by=%0d expected by=%0d", t, bx, by, ay[t]); end
      vectors++; if (alive[ki[t]] !== 1'b0) begin miscompares++; $display("FAIL plan%0d_alive: got %0d expected 0", t, alive[ki[t]]); end
      vectors++; if (score !== 8'(t + 1)) begin miscompares++; $display("FAIL plan%0d_score: got %0d expected %0d", t, score, t + 1); end
      vectors++; if (fl !== ki[t] + 2) begin miscompares++; $display("FAIL plan%0d_busy_fall: got %0d expected %0d", t, fl, ki[t] + 2); end
    end
  endtask

  task automatic test_no_hit();
    int hc, fl, nh, eh, ef; bit bx, by, eby;
    logic [N-1:0] a0; logic [7:0] s0;
    a0 = alive; s0 = score;
    observe_tick(320, 300, 1'b1, 1'b0, hc, bx, by, fl, nh);
    model_apply(320, 300, 1'b1, eh, ef, eby);
    vectors++; if (nh !== 0) begin miscompares++; $display("FAIL nohit_pulses: got %0d expected 0", nh); end
    vectors++; if (fl !== N) begin miscompares++; $display("FAIL nohit_busy_fall: got %0d expected %0d", fl, N); end
    vectors++; if (alive !== a0 || score !== s0) begin miscompares++; $display("FAIL nohit_state: got %h/%0d expected %h/%0d", alive, score, a0, s0); end
  endtask

  task automatic test_random();
    int hc, fl, nh, eh, ef, x, y, b; bit bx, by, eby, st, ex;
    for (int t = 0; t < 50; t++) begin
      st = ($urandom_range(0, 7) != 0);
      ex = ($urandom_range(0, 3) == 0);
      if (t % 5 == 4) begin
        x = $urandom_range(0, 639); y = $urandom_range(0, 479);
      end else begin
        b = $urandom_range(0, N - 1);
        x = X0 + (b % N_COLS) * 2 * W_BLOCK + $urandom_range(0, 96) - 48;
        y = Y0 + (b / N_COLS) * 2 * H_BLOCK + m_off + $urandom_range(0, 40) - 20;
        if (x < 0) x = 0;
      end
      observe_tick(x, y, st, ex, hc, bx, by, fl, nh);
      model_apply(x, y, st, eh, ef, eby);
      vectors++; if (hc !== eh) begin miscompares++; $display("FAIL rand%0d_hit_cycle (%0d,%0d): got %0d expected %0d", t, x, y, hc, eh); end
      if (eh >= 0) begin
        vectors++; if ({bx, by} !== {!eby, eby}) begin miscompares++; $display("FAIL rand%0d_axis: got bx=%0d by=%0d expected by=%0d", t, bx, by, eby); end
      end
      vectors++; if (fl !== ef) begin miscompares++; $display("FAIL rand%0d_busy_fall: got %0d expected %0d", t, fl, ef); end
      vectors++; if (nh !== (eh >= 0 ? 1 : 0)) begin miscompares++; $display("FAIL rand%0d_pulses: got %0d expected %0d", t, nh, eh >= 0 ? 1 : 0); end
      vectors++; if (alive !== model_vec()) begin miscompares++; $display("FAIL rand%0d_alive: got %h expected %h", t, alive, model_vec()); end
      vectors++; if (score !== 8'(m_score)) begin miscompares++; $display("FAIL rand%0d_score: got %0d expected %0d", t, score, m_score); end
    end
  endtask

  task automatic test_clear_all();
    int hc, fl, nh, eh, ef, x, y; bit bx, by, eby;
    for (int i = 0; i < N; i++) begin
      if (m_alive[i]) begin
        x = X0 + (i % N_COLS) * 2 * W_BLOCK;
        y = Y0 + (i / N_COLS) * 2 * H_BLOCK + m_off;
        observe_tick(x, y, 1'b1, 1'b0, hc, bx, by, fl, nh);
        model_apply(x, y, 1'b1, eh, ef, eby);
        vectors++; if (hc !== eh) begin miscompares++; $display("FAIL clear%0d_hit_cycle: got %0d expected %0d", i, hc, eh); end
      end
    end
    vectors++; if (all_clear !== 1'b1 || alive !== '0) begin miscompares++; $display("FAIL clear_all_clear: got %0d/%h expected 1/0", all_clear, alive); end
    vectors++; if (score !== 8'(m_score)) begin miscompares++; $display("FAIL clear_score: got %0d expected %0d", score, m_score); end
    observe_tick(160, 70, 1'b1, 1'b0, hc, bx, by, fl, nh);
    vectors++; if (fl !== 0 || nh !== 0) begin miscompares++; $display("FAIL clear_blocks_scan: got fall=%0d hits=%0d expected 0/0", fl, nh); end
  endtask

  task automatic test_drop_endgame();
    int exp_off; bit exp_eg;
    do_reset();
    d_start = 1'b1; d_x_ball = 10'd0; d_y_ball = 10'd0;
    for (int t = 1; t <= 25; t++) begin
      @(negedge clock); d_frame_tick = 1'b1;
      @(negedge clock); d_frame_tick = 1'b0;
      if (t > 23) begin
        vectors++; if (d_busy !== 1'b0) begin miscompares++; $display("FAIL drop_tick%0d_busy: got %0d expected 0", t, d_busy); end
      end
      repeat (N + 4) @(negedge clock);
      exp_off = (t <= 23) ? DROP_PX * t : DROP_PX * 23;
      exp_eg  = (Y0 + (N_ROWS - 1) * 2 * H_BLOCK + exp_off + H_BLOCK >= 464);
      vectors++; if (d_y_offset !== 10'(exp_off)) begin miscompares++; $display("FAIL drop_tick%0d_y_offset: got %0d expected %0d", t, d_y_offset, exp_off); end
      vectors++; if (d_endgame !== exp_eg) begin miscompares++; $display("FAIL drop_tick%0d_endgame: got %0d expected %0d", t, d_endgame, exp_eg); end
    end
    vectors++; if (d_score !== 8'd0) begin miscompares++; $display("FAIL drop_score: got %0d expected 0", d_score); end
  endtask

  task automatic test_reset_midscan();
    int nh;
    do_reset();
    @(negedge clock);
    x_ball = 10'd160; y_ball = 10'd70; start = 1'b1; frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    nh = 0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clock);
      if (hit_block) nh++;
    end
    reset = 1'b1;
    @(negedge clock);
    vectors++; if (busy !== 1'b0 || hit_block !== 1'b0) begin miscompares++; $display("FAIL midrst_busy_hit: got %0d/%0d expected 0/0", busy, hit_block); end
    vectors++; if (alive !== {N{1'b1}} || score !== 8'd0 || y_offset !== 10'd0) begin
      miscompares++; $display("FAIL midrst_state: got %h/%0d/%0d expected all ones/0/0", alive, score, y_offset); end
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 25; c++) begin
      @(negedge clock);
      if (hit_block) nh++;
    end
    vectors++; if (nh !== 0) begin miscompares++; $display("FAIL midrst_pulses: got %0d expected 0", nh); end
    vectors++; if (alive !== {N{1'b1}} || score !== 8'd0) begin miscompares++; $display("FAIL midrst_after: got %h/%0d expected all ones/0", alive, score); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; frame_tick = 1'b0; x_ball = '0; y_ball = '0;
    d_start = 1'b0; d_frame_tick = 1'b0; d_x_ball = '0; d_y_ball = '0;
    model_reset();
    test_reset();
    test_plan_hits();
    test_no_hit();
    test_random();
    test_clear_all();
    test_drop_endgame();
    test_reset_midscan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
